// File: rtl/ram_mfc_memory_if.sv
// ----------------------------------------------------------------------------
// ram_mfc_memory_if
//   Request/response bundle between the control unit and the byte-addressed
//   memory. The control unit sits on the master side, the memory on the slave.
//   mfa      : memory function activate (request), held until mfc seen
//   rw       : 1 = read, 0 = write
//   address  : byte address of the first (most significant) byte
//   dataSize : 00 byte, 01 halfword, 10 word, 11 reserved
//   dataIn   : right-justified write data
//   dataOut  : right-justified, zero-extended read data
//   mfc      : memory function complete
//   err      : access rejected; meaningful while mfc=1
// ----------------------------------------------------------------------------
interface ram_mfc_memory_if #(
    parameter int ADDR_W = 9
);
    logic              mfa;
    logic              rw;
    logic [ADDR_W-1:0] address;
    logic [1:0]        dataSize;
    logic [31:0]       dataIn;
    logic [31:0]       dataOut;
    logic              mfc;
    logic              err;

    modport master (
        output mfa, rw, address, dataSize, dataIn,
        input  dataOut, mfc, err
    );

    modport slave (
        input  mfa, rw, address, dataSize, dataIn,
        output dataOut, mfc, err
    );
endinterface

// File: rtl/ram_mfc_memory.sv
// ----------------------------------------------------------------------------
// ram_mfc_memory
//   Big-endian byte-addressed memory of 2**ADDR_W bytes behind a four-phase
//   MFA/MFC handshake. A request is captured in IDLE, completes LATENCY edges
//   later (mfc=1), and mfc/err hold until the requester drops mfa.
//   Misaligned halfword/word accesses and the reserved size are rejected
//   with err=1 and leave memory and dataOut untouched.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset (memory contents are kept)
//   bus   : slave side of ram_mfc_memory_if
// ----------------------------------------------------------------------------
module ram_mfc_memory #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2     // 1..15
) (
    input  logic                clk,
    input  logic                reset,
    ram_mfc_memory_if.slave     bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt,   w_cnt_nxt;
    logic              r_mfc,   w_mfc_nxt;
    logic              r_err,   w_err_nxt;
    logic [31:0]       r_dout,  w_dout_nxt;

    // Request fields latched at capture; later input changes are ignored.
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [1:0]        r_size;
    logic [31:0]       r_din;

    logic [7:0]        r_mem [DEPTH];

    logic              w_capture;
    logic              w_access;
    logic              w_ok;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [31:0]       w_rd_data;

    // Aligned accesses never cross the top of memory, so plain increments
    // are enough for the trailing byte addresses.
    assign w_a0 = r_addr;
    assign w_a1 = r_addr + ADDR_W'(1);
    assign w_a2 = r_addr + ADDR_W'(2);
    assign w_a3 = r_addr + ADDR_W'(3);

    always_comb begin
        w_ok = 1'b0;
        case (r_size)
            2'b00:   w_ok = 1'b1;
            2'b01:   w_ok = (r_addr[0] == 1'b0);
            2'b10:   w_ok = (r_addr[1:0] == 2'b00);
            default: w_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (r_size)
            2'b00:   w_rd_data = {24'd0, r_mem[w_a0]};
            2'b01:   w_rd_data = {16'd0, r_mem[w_a0], r_mem[w_a1]};
            2'b10:   w_rd_data = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
            default: w_rd_data = 32'd0;
        endcase
    end

    // Completion happens only if mfa is still high on the final WAIT edge;
    // a simultaneous drop is an abort.
    assign w_access = (r_state == S_WAIT) && bus.mfa && (r_cnt == 4'(LATENCY - 1));
    assign w_wr_en  = w_access && w_ok && !r_rw;

    // Next-state / output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mfc_nxt   = r_mfc;
        w_err_nxt   = r_err;
        w_dout_nxt  = r_dout;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mfa) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.mfa) begin
                    w_state_nxt = S_IDLE;
                end else if (w_access) begin
                    w_mfc_nxt   = 1'b1;
                    w_err_nxt   = !w_ok;
                    if (w_ok && r_rw)
                        w_dout_nxt = w_rd_data;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                if (!bus.mfa) begin
                    w_mfc_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mfc   <= w_mfc_nxt;
            r_err   <= w_err_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_rw   <= 1'b0;
            r_size <= 2'b00;
            r_din  <= 32'd0;
        end else if (w_capture) begin
            r_addr <= bus.address;
            r_rw   <= bus.rw;
            r_size <= bus.dataSize;
            r_din  <= bus.dataIn;
        end
    end

    // Storage is not reset; writes are gated by reset so nothing lands
    // while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && w_wr_en) begin
            case (r_size)
                2'b00: r_mem[w_a0] <= r_din[7:0];
                2'b01: begin
                    r_mem[w_a0] <= r_din[15:8];
                    r_mem[w_a1] <= r_din[7:0];
                end
                2'b10: begin
                    r_mem[w_a0] <= r_din[31:24];
                    r_mem[w_a1] <= r_din[23:16];
                    r_mem[w_a2] <= r_din[15:8];
                    r_mem[w_a3] <= r_din[7:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.mfc     = r_mfc;
    assign bus.err     = r_err;
    assign bus.dataOut = r_dout;
endmodule

// File: tb/tb_ram_mfc_memory.sv
// ----------------------------------------------------------------------------
// tb_ram_mfc_memory
//   Drives the memory through the master side of the interface and compares
//   every handshake outcome with a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_ram_mfc_memory;
    localparam int ADDR_W  = 9;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ram_mfc_memory_if #(.ADDR_W(ADDR_W)) mif ();

    ram_mfc_memory #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_mem [DEPTH];
    logic [31:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit legal(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 1'b1;
            2'b01:   return (a % 2) == 0;
            2'b10:   return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Apply one complete request to the model.
    task automatic model_access(input bit rd, input logic [ADDR_W-1:0] a,
                                input logic [1:0] sz, input logic [31:0] din);
        int n;
        logic [31:0] v;
        if (!legal(a, sz)) return;
        n = 1 << sz;
        if (rd) begin
            v = 0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(m_mem[int'(a) + i]);
            m_dout = v;
        end else begin
            for (int i = 0; i < n; i++) m_mem[int'(a) + i] = 8'(din >> (8 * (n - 1 - i)));
        end
    endtask

    // Full four-phase transaction; hold = extra cycles mfa stays high in DONE.
    task automatic xfer(input bit rd, input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                        input logic [31:0] din, input int hold);
        int cyc;
        bit ok;
        ok = legal(a, sz);
        @(negedge clk);
        mif.mfa      = 1'b1;
        mif.rw       = rd;
        mif.address  = a;
        mif.dataSize = sz;
        mif.dataIn   = din;
        @(posedge clk);                       // capture edge
        @(negedge clk);
        // Post-capture input changes must have no effect.
        mif.address  = ADDR_W'($urandom);
        mif.dataIn   = $urandom;
        mif.rw       = 1'($urandom);
        mif.dataSize = 2'($urandom);
        cyc = 0;
        while (!mif.mfc && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, LATENCY);
        model_access(rd, a, sz, din);
        chk("err", {31'd0, mif.err}, {31'd0, !ok});
        chk("dataOut", mif.dataOut, m_dout);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("mfc_hold", {31'd0, mif.mfc}, 32'd1);
            chk("err_hold", {31'd0, mif.err}, {31'd0, !ok});
        end
        @(negedge clk);
        mif.mfa = 1'b0;
        @(posedge clk); #1;
        chk("mfc_drop", {31'd0, mif.mfc}, 32'd0);
        chk("err_drop", {31'd0, mif.err}, 32'd0);
        chk("dataOut_keep", mif.dataOut, m_dout);
    endtask

    // Request dropped on the edge where it would have completed.
    task automatic xfer_abort(input bit rd, input logic [ADDR_W-1:0] a,
                              input logic [1:0] sz, input logic [31:0] din);
        @(negedge clk);
        mif.mfa      = 1'b1;
        mif.rw       = rd;
        mif.address  = a;
        mif.dataSize = sz;
        mif.dataIn   = din;
        @(posedge clk);                       // capture
        repeat (LATENCY - 1) @(posedge clk);
        @(negedge clk);
        mif.mfa = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_mfc", {31'd0, mif.mfc}, 32'd0);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [1:0]        sz;
        n_tests      = 0;
        n_fail       = 0;
        m_dout       = 32'd0;
        reset        = 1'b0;
        mif.mfa      = 1'b0;
        mif.rw       = 1'b0;
        mif.address  = '0;
        mif.dataSize = 2'b00;
        mif.dataIn   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mfc", {31'd0, mif.mfc}, 32'd0);
        chk("rst_err", {31'd0, mif.err}, 32'd0);
        chk("rst_dout", mif.dataOut, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Give every byte a known value.
        for (int i = 0; i < DEPTH / 4; i++)
            xfer(1'b0, ADDR_W'(i * 4), 2'b10, $urandom, 0);

        // Write word, read back in three widths
        xfer(1'b0, 9'h004, 2'b10, 32'hDEADBEEF, 0);
        xfer(1'b1, 9'h004, 2'b10, 32'd0, 0);
        chk("rd_word_004", mif.dataOut, 32'hDEADBEEF);
        xfer(1'b1, 9'h005, 2'b00, 32'd0, 0);
        chk("rd_byte_005", mif.dataOut, 32'h000000AD);
        xfer(1'b1, 9'h006, 2'b01, 32'd0, 0);
        chk("rd_half_006", mif.dataOut, 32'h0000BEEF);

        // Misaligned / reserved
        xfer(1'b0, 9'h002, 2'b10, 32'h12345678, 0);
        xfer(1'b1, 9'h000, 2'b10, 32'd0, 0);
        xfer(1'b1, 9'h003, 2'b01, 32'd0, 0);
        xfer(1'b1, 9'h008, 2'b11, 32'd0, 0);
        xfer(1'b0, 9'h008, 2'b11, 32'hFFFFFFFF, 0);
        xfer(1'b1, 9'h008, 2'b10, 32'd0, 0);

        // Abort with mfa falling on the completion edge
        xfer_abort(1'b0, 9'h010, 2'b10, 32'hCAFEF00D);
        xfer(1'b1, 9'h010, 2'b10, 32'd0, 0);

        // Asynchronous reset in WAIT, between edges
        xfer(1'b1, 9'h004, 2'b10, 32'd0, 0);
        @(negedge clk);
        mif.mfa      = 1'b1;
        mif.rw       = 1'b0;
        mif.address  = 9'h004;
        mif.dataSize = 2'b10;
        mif.dataIn   = 32'h11111111;
        @(posedge clk);
        #3;
        reset = 1'b0;
        m_dout = 32'd0;
        #1;
        chk("arst_mfc", {31'd0, mif.mfc}, 32'd0);
        chk("arst_err", {31'd0, mif.err}, 32'd0);
        chk("arst_dout", mif.dataOut, 32'd0);
        mif.mfa = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        xfer(1'b1, 9'h004, 2'b10, 32'd0, 0);
        chk("after_rst_004", mif.dataOut, 32'hDEADBEEF);

        // Top byte and long DONE hold
        xfer(1'b0, 9'h1FF, 2'b00, 32'h000000A5, 5);
        xfer(1'b1, 9'h1FF, 2'b00, 32'd0, 5);
        chk("rd_byte_1ff", mif.dataOut, 32'h000000A5);
        xfer(1'b1, 9'h1FC, 2'b10, 32'd0, 0);

        // Random traffic, mostly aligned so that most requests succeed
        for (int k = 0; k < 200; k++) begin
            a  = ADDR_W'($urandom);
            sz = 2'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0]   = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0)
                xfer_abort(1'($urandom), a, sz, $urandom);
            else
                xfer(1'($urandom), a, sz, $urandom, $urandom_range(0, 3));
        end

        // Final sweep: whole memory must match the model
        for (int i = 0; i < DEPTH / 4; i++)
            xfer(1'b1, ADDR_W'(i * 4), 2'b10, 32'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
